// File: rtl/sensor_pkg.sv
// Shared types and constants for the intrusion alarm scan controller.
package sensor_pkg;

    // Scan sequencer states: one sensor is powered and sampled at a time.
    typedef enum logic [2:0] {
        SCAN_IDLE       = 3'd0,
        SCAN_IR_SETTLE  = 3'd1,
        SCAN_IR_SAMPLE  = 3'd2,
        SCAN_PD_SETTLE  = 3'd3,
        SCAN_PD_SAMPLE  = 3'd4,
        SCAN_SND_SAMPLE = 3'd5
    } scan_state_e;

    // Alarm sequence progress as seen on the stage output.
    localparam logic [1:0] STAGE_IDLE  = 2'b00;
    localparam logic [1:0] STAGE_IR    = 2'b01;
    localparam logic [1:0] STAGE_PD    = 2'b10;
    localparam logic [1:0] STAGE_ALARM = 2'b11;

    // Advances the sequence only when the detection matching the current
    // stage arrives; anything out of order leaves the stage untouched.
    function automatic logic [1:0] next_stage(input logic [1:0] cur,
                                              input logic       ir_hit,
                                              input logic       pd_hit,
                                              input logic       snd_hit);
        logic [1:0] nxt;
        nxt = cur;
        case (cur)
            STAGE_IDLE: if (ir_hit)  nxt = STAGE_IR;
            STAGE_IR:   if (pd_hit)  nxt = STAGE_PD;
            STAGE_PD:   if (snd_hit) nxt = STAGE_ALARM;
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/hit_filter.sv
// Consecutive-hit filter for one sensor. The count only moves in the
// sensor's sample cycle; detected is a combinational strobe that the
// parent registers so the pulse lands in the cycle after the sample.
module hit_filter #(
    parameter int HIT_COUNT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_en,
    input  logic din,
    input  logic clr,
    output logic detected
);

    localparam int CW = $clog2(HIT_COUNT + 1);
    localparam logic [CW-1:0] HIT_MAX = CW'(HIT_COUNT);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturating hit count: a miss clears it, and only the increment that
    // reaches the threshold strobes detected, so a held input fires once.
    always_comb begin
        cnt_d    = cnt_q;
        detected = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (sample_en) begin
            if (din) begin
                if (cnt_q != HIT_MAX) begin
                    cnt_d    = cnt_q + ONE;
                    detected = (cnt_q == HIT_MAX - ONE);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Hit count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/intrusion_scan_ctrl.sv
// Power-gated scan controller for the intrusion alarm: sequences the IR
// emitter and photodiode bias, filters each sensor over consecutive scans,
// tracks the IR -> PD -> sound order and drives a pulsed buzzer on alarm.
module intrusion_scan_ctrl
    import sensor_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int HIT_COUNT  = 3,
    parameter int BUZZ_HALF  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic       clear,
    input  logic       ir_sensor_data,
    input  logic       pd_sensor_data,
    input  logic       sound_data,
    output logic       ir_emit_en,
    output logic       pd_bias_en,
    output logic       ir_detected,
    output logic       pd_detected,
    output logic       sound_detected,
    output logic [1:0] stage,
    output logic       buzzer_trigger,
    output logic       armed
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int BW = $clog2(BUZZ_HALF + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [BW-1:0] BUZZ_LAST   = BW'(BUZZ_HALF - 1);
    localparam logic [BW-1:0] BUZZ_ONE    = BW'(1);

    logic [1:0]    ir_sync_q;
    logic [1:0]    pd_sync_q;
    logic [1:0]    snd_sync_q;

    scan_state_e   state_q;
    scan_state_e   state_d;
    logic [SW-1:0] settle_q;
    logic [SW-1:0] settle_d;

    logic          ir_hit;
    logic          pd_hit;
    logic          snd_hit;
    logic [2:0]    det_q;

    logic [1:0]    stage_q;
    logic [1:0]    stage_d;

    logic          buzz_q;
    logic          buzz_d;
    logic          buzz_run_q;
    logic          buzz_run_d;
    logic [BW-1:0] buzz_cnt_q;
    logic [BW-1:0] buzz_cnt_d;

    logic          armed_q;

    // Two-flop synchronizers for the asynchronous sensor pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_sync_q  <= '0;
            pd_sync_q  <= '0;
            snd_sync_q <= '0;
        end else begin
            ir_sync_q  <= {ir_sync_q[0], ir_sensor_data};
            pd_sync_q  <= {pd_sync_q[0], pd_sensor_data};
            snd_sync_q <= {snd_sync_q[0], sound_data};
        end
    end

    // Scan sequencer next state: settle phases run SETTLE_CYC cycles, each
    // sample phase a single cycle; disarm drops straight back to idle.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (!arm) begin
            state_d  = SCAN_IDLE;
            settle_d = '0;
        end else begin
            case (state_q)
                SCAN_IDLE: begin
                    state_d  = SCAN_IR_SETTLE;
                    settle_d = '0;
                end
                SCAN_IR_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = SCAN_IR_SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SETTLE_ONE;
                    end
                end
                SCAN_IR_SAMPLE: state_d = SCAN_PD_SETTLE;
                SCAN_PD_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = SCAN_PD_SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SETTLE_ONE;
                    end
                end
                SCAN_PD_SAMPLE:  state_d = SCAN_SND_SAMPLE;
                SCAN_SND_SAMPLE: state_d = SCAN_IR_SETTLE;
                default: begin
                    state_d  = SCAN_IDLE;
                    settle_d = '0;
                end
            endcase
        end
    end

    // Scan sequencer state register; reset forces idle, which drops both
    // power enables without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SCAN_IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    assign ir_emit_en = (state_q == SCAN_IR_SETTLE) || (state_q == SCAN_IR_SAMPLE);
    assign pd_bias_en = (state_q == SCAN_PD_SETTLE) || (state_q == SCAN_PD_SAMPLE);

    hit_filter #(.HIT_COUNT(HIT_COUNT)) u_ir_filter (
        .clk       (clk),
        .reset     (reset),
        .sample_en (state_q == SCAN_IR_SAMPLE),
        .din       (ir_sync_q[1]),
        .clr       (!arm),
        .detected  (ir_hit)
    );

    hit_filter #(.HIT_COUNT(HIT_COUNT)) u_pd_filter (
        .clk       (clk),
        .reset     (reset),
        .sample_en (state_q == SCAN_PD_SAMPLE),
        .din       (pd_sync_q[1]),
        .clr       (!arm),
        .detected  (pd_hit)
    );

    hit_filter #(.HIT_COUNT(HIT_COUNT)) u_snd_filter (
        .clk       (clk),
        .reset     (reset),
        .sample_en (state_q == SCAN_SND_SAMPLE),
        .din       (snd_sync_q[1]),
        .clr       (!arm),
        .detected  (snd_hit)
    );

    // Stage next value: clear and disarm take priority over any detection.
    always_comb begin
        stage_d = stage_q;
        if (!arm || clear) begin
            stage_d = STAGE_IDLE;
        end else begin
            stage_d = next_stage(stage_q, ir_hit, pd_hit, snd_hit);
        end
    end

    // Buzzer timer: goes high on the first alarm cycle, then toggles every
    // BUZZ_HALF cycles; leaving the alarm stage silences and rewinds it.
    always_comb begin
        buzz_d     = buzz_q;
        buzz_run_d = buzz_run_q;
        buzz_cnt_d = buzz_cnt_q;
        if (!arm || clear || (stage_q != STAGE_ALARM)) begin
            buzz_d     = 1'b0;
            buzz_run_d = 1'b0;
            buzz_cnt_d = '0;
        end else if (!buzz_run_q) begin
            buzz_d     = 1'b1;
            buzz_run_d = 1'b1;
            buzz_cnt_d = '0;
        end else if (buzz_cnt_q == BUZZ_LAST) begin
            buzz_d     = ~buzz_q;
            buzz_cnt_d = '0;
        end else begin
            buzz_cnt_d = buzz_cnt_q + BUZZ_ONE;
        end
    end

    // Registered detection pulses, stage, buzzer and armed status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_q      <= '0;
            stage_q    <= STAGE_IDLE;
            buzz_q     <= 1'b0;
            buzz_run_q <= 1'b0;
            buzz_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            det_q      <= {ir_hit, pd_hit, snd_hit};
            stage_q    <= stage_d;
            buzz_q     <= buzz_d;
            buzz_run_q <= buzz_run_d;
            buzz_cnt_q <= buzz_cnt_d;
            armed_q    <= arm;
        end
    end

    assign ir_detected    = det_q[2];
    assign pd_detected    = det_q[1];
    assign sound_detected = det_q[0];
    assign stage          = stage_q;
    assign buzzer_trigger = buzz_q;
    assign armed          = armed_q;

endmodule
